// File: rtl/apb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// apb_regfile_pkg : shared types, constants and address decode helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_regfile_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam int WS_CNT_W = 4;

  // Misaligned offsets and indices past the last register both decode as errors.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int          num_regs,
                                    input int          bytes_per_word);
    logic [63:0] ofs_mask;
    logic [63:0] idx;
    ofs_mask = 64'(bytes_per_word) - 64'd1;
    idx      = addr >> $clog2(bytes_per_word);
    return ((addr & ofs_mask) != 64'd0) || (idx >= 64'(num_regs));
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regfile_ws_wait.sv
// ---------------------------------------------------------------------------
// apb_wait_ctrl : APB IDLE/ACCESS sequencer with programmable wait states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_wait_ctrl
  import apb_regfile_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic i_pclk,
  input  logic i_presetn,
  input  logic i_psel,
  input  logic i_penable,
  output logic o_pready
);

  apb_state_t          r_state;
  logic [WS_CNT_W-1:0] r_cnt;
  logic                w_ready;

  assign w_ready  = (r_state == ACCESS) && i_psel && i_penable && (r_cnt == '0);
  assign o_pready = w_ready;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_psel && !i_penable) begin
            r_state <= ACCESS;
            r_cnt   <= WS_CNT_W'(WAIT_STATES);
          end
        end
        ACCESS: begin
          // Dropping PSEL mid-access is an abort: return to IDLE without completing.
          if (!i_psel || w_ready) begin
            r_state <= IDLE;
          end else if (i_penable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_regfile_ws.sv
// ---------------------------------------------------------------------------
// apb_regfile_ws : parametrised APB register file with wait states and PSLVERR
// Optional macro APB_PSTRB_EN adds PSTRB byte-lane write strobes.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_regfile_ws
  import apb_regfile_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_REGS    = 4,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int BPW   = DATA_W / 8;
  localparam int OFS_W = $clog2(BPW);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_pready;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_wmask;

  apb_wait_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_ctrl (
    .i_pclk    (PCLK),
    .i_presetn (PRESETn),
    .i_psel    (PSEL),
    .i_penable (PENABLE),
    .o_pready  (w_pready)
  );

  // The truncated index is only consumed when the full-width decode reports no error.
  assign w_err   = addr_err(64'(PADDR), NUM_REGS, BPW);
  assign w_idx   = IDX_W'(PADDR >> OFS_W);
  assign w_wr_en = w_pready && PWRITE && !w_err;
  assign w_rd_en = w_pready && !PWRITE && !w_err;

`ifdef APB_PSTRB_EN
  for (genvar g = 0; g < BPW; g++) begin : g_lane
    assign w_wmask[8*g +: 8] = {8{PSTRB[g]}};
  end
`else
  assign w_wmask = '1;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          r_regs[i] <= (r_regs[i] & ~w_wmask) | (PWDATA & w_wmask);
        end
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          PRDATA = r_regs[i];
        end
      end
    end
  end

  assign PREADY  = w_pready;
  assign PSLVERR = w_pready && w_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile_ws.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_ws : directed checks of apb_regfile_ws at 0, 2 and 3 wait states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_regfile_ws;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];

  int          sel;
  logic        m_ready;
  logic        m_err;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  always_comb begin
    m_ready = pready_v[sel];
    m_err   = pslverr_v[sel];
    m_rdata = prdata_v[sel];
  end

  apb_regfile_ws #(.WAIT_STATES(0)) u_dut0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_v[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_v[0]), .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0])
  );

  apb_regfile_ws #(.WAIT_STATES(2)) u_dut2 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_v[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_v[1]), .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1])
  );

  apb_regfile_ws #(.WAIT_STATES(3)) u_dut3 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_v[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_v[2]), .PREADY(pready_v[2]), .PSLVERR(pslverr_v[2])
  );

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // One full APB transfer on DUT 'which'; reports data, error and PREADY-low access cycles.
  task automatic xfer(input int which, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rdata = '0;
    err   = 1'b0;
    sel   = which;
    @(posedge pclk); #1;
    psel_v        = '0;
    psel_v[which] = 1'b1;
    penable       = 1'b0;
    pwrite        = wr;
    paddr         = addr;
    pwdata        = wdata;
    pstrb         = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int n = 0; n < 32 && !done; n++) begin
      @(negedge pclk);
      if (m_ready) begin
        done  = 1'b1;
        rdata = m_rdata;
        err   = m_err;
      end else begin
        waits++;
        chk("pslverr_low_while_waiting", 32'(m_err), 32'd0);
        @(posedge pclk); #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout actual=no_PREADY required=PREADY_within_32_cycles");
    end
    @(posedge pclk); #1;
    psel_v  = '0;
    penable = 1'b0;
    @(negedge pclk);
    chk("pready_single_cycle", 32'(m_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ws;

    #200000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ws;

    presetn = 1'b0;
    psel_v  = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = 4'hF;
    sel     = 0;

    vq.push_back(mk("w0",     1'b1, 32'h0,  32'd15,       4'hF, 32'h0, 1'b0));
    vq.push_back(mk("w4",     1'b1, 32'h4,  32'd25122023, 4'hF, 32'h0, 1'b0));
    vq.push_back(mk("w8",     1'b1, 32'h8,  32'h4976616E, 4'hF, 32'h0, 1'b0));
    vq.push_back(mk("wC",     1'b1, 32'hC,  32'h50657472, 4'hF, 32'h0, 1'b0));
    vq.push_back(mk("r0",     1'b0, 32'h0,  32'h0,        4'hF, 32'd15,       1'b0));
    vq.push_back(mk("r4",     1'b0, 32'h4,  32'h0,        4'hF, 32'd25122023, 1'b0));
    vq.push_back(mk("r8",     1'b0, 32'h8,  32'h0,        4'hF, 32'h4976616E, 1'b0));
    vq.push_back(mk("rC",     1'b0, 32'hC,  32'h0,        4'hF, 32'h50657472, 1'b0));
    vq.push_back(mk("werr10", 1'b1, 32'h10, 32'h1234,     4'hF, 32'h0, 1'b1));
    vq.push_back(mk("werr6",  1'b1, 32'h6,  32'hFFFF,     4'hF, 32'h0, 1'b1));
    vq.push_back(mk("r0_b",   1'b0, 32'h0,  32'h0,        4'hF, 32'd15,       1'b0));
    vq.push_back(mk("r4_b",   1'b0, 32'h4,  32'h0,        4'hF, 32'd25122023, 1'b0));
    vq.push_back(mk("r8_b",   1'b0, 32'h8,  32'h0,        4'hF, 32'h4976616E, 1'b0));
    vq.push_back(mk("rC_b",   1'b0, 32'hC,  32'h0,        4'hF, 32'h50657472, 1'b0));
    vq.push_back(mk("rerr10", 1'b0, 32'h10, 32'h0,        4'hF, 32'h0, 1'b1));
    vq.push_back(mk("rerr2",  1'b0, 32'h2,  32'h0,        4'hF, 32'h0, 1'b1));
`ifdef APB_PSTRB_EN
    vq.push_back(mk("wstrb1", 1'b1, 32'h8,  32'h00000041, 4'h1, 32'h0, 1'b0));
    vq.push_back(mk("rstrb1", 1'b0, 32'h8,  32'h0,        4'h1, 32'h49766141, 1'b0));
    vq.push_back(mk("wstrb0", 1'b1, 32'h8,  32'hFFFFFFFF, 4'h0, 32'h0, 1'b0));
    vq.push_back(mk("rstrb0", 1'b0, 32'h8,  32'h0,        4'h0, 32'h49766141, 1'b0));
`endif

    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready",  32'(pready_v),  32'd0);
    chk("rst_pslverr", 32'(pslverr_v), 32'd0);
    for (int d = 0; d < 3; d++) chk("rst_prdata", prdata_v[d], 32'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Zero-wait-state table
    foreach (vq[i]) begin
      xfer(0, vq[i].wr, vq[i].addr, vq[i].wdata, vq[i].strb, rd, er, ws);
      chk({vq[i].name, "_rdata"},   rd,        vq[i].exp_rdata);
      chk({vq[i].name, "_pslverr"}, 32'(er),   32'(vq[i].exp_err));
      chk({vq[i].name, "_waits"},   32'(ws),   32'd0);
    end

    // PENABLE without a setup phase must be ignored
    @(posedge pclk); #1;
    sel = 0; psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h77;
    repeat (2) begin
      @(negedge pclk);
      chk("noset_pready", 32'(pready_v[0]), 32'd0);
      @(posedge pclk); #1;
    end
    psel_v = '0; penable = 1'b0;
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, ws);
    chk("noset_r0", rd, 32'd15);

    // Three wait states
    xfer(2, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, er, ws);
    chk("ws3_w_waits", 32'(ws), 32'd3);
    chk("ws3_w_err",   32'(er), 32'd0);
    xfer(2, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, ws);
    chk("ws3_r_waits", 32'(ws), 32'd3);
    chk("ws3_r_data",  rd,      32'hDEADBEEF);

    // Abort on the two-wait-state instance
    xfer(1, 1'b1, 32'h0, 32'd15, 4'hF, rd, er, ws);
    chk("ws2_w_waits", 32'(ws), 32'd2);
    @(posedge pclk); #1;
    sel = 1; psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hAAAA5555;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort_pready_acc1", 32'(pready_v[1]), 32'd0);
    @(posedge pclk); #1;
    psel_v = '0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready_drop", 32'(pready_v[1]), 32'd0);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, ws);
    chk("abort_r0_data",  rd,      32'd15);
    chk("abort_r0_waits", 32'(ws), 32'd2);
    chk("abort_r0_err",   32'(er), 32'd0);

    // Reset while the three-wait-state instance has two waits left
    @(posedge pclk); #1;
    sel = 2; psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55555555;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("rstmid_pready",  32'(pready_v[2]),  32'd0);
    chk("rstmid_pslverr", 32'(pslverr_v[2]), 32'd0);
    psel_v = '0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      xfer(2, 1'b0, 32'(4 * r), 32'h0, 4'hF, rd, er, ws);
      chk("rstmid_readback", rd, 32'd0);
    end

    // Reset during a completion cycle: PREADY drops at once and the write is lost
    @(posedge pclk); #1;
    sel = 0; psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h99;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("rstcmp_pready_before", 32'(pready_v[0]), 32'd1);
    #1;
    presetn = 1'b0;
    #1;
    chk("rstcmp_pready_after",  32'(pready_v[0]),  32'd0);
    chk("rstcmp_pslverr_after", 32'(pslverr_v[0]), 32'd0);
    chk("rstcmp_prdata_after",  prdata_v[0],       32'd0);
    psel_v = '0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      xfer(0, 1'b0, 32'(4 * r), 32'h0, 4'hF, rd, er, ws);
      chk("rstcmp_readback", rd, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
